load_store_unit: RTL and testbench

//   MEM stage of the RV64I pipeline. Consumes the EX-stage effective address (ALU sum
//   rs1+imm) and store data (rs2). Issues one aligned 64-bit data-memory access per

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV64I MEM stage: one aligned 64-bit data-memory access per op, with store lane
// steering, load extraction and extension, and misaligned/illegal-op reporting.
module load_store_unit #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [XLEN-1:0]   dmem_addr,
  output logic              dmem_we,
  output logic [STRB_W-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [XLEN-1:0]   exc_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [2:0]  off_q;
  logic [4:0]  rd_q;

  logic              accept, illegal, misal, fault;
  logic [1:0]        cause;
  logic [STRB_W-1:0] strb;
  logic [XLEN-1:0]   rep;
  logic [XLEN-1:0]   shifted, ext;

  assign accept  = (state == IDLE) && ex_valid && (ex_is_load || ex_is_store);
  // A store cannot use the unsigned encodings; both flags set means load.
  assign illegal = (ex_funct3 == 3'b111) || (!ex_is_load && ex_funct3[2]);
  assign fault   = illegal || misal;
  assign cause   = illegal ? 2'd2 : (ex_is_load ? 2'd0 : 2'd1);

  always_comb begin
    misal = 1'b0;
    strb  = '1;
    rep   = ex_wdata;
    unique case (ex_funct3[1:0])
      2'd0: begin
        strb = 8'h01 << ex_addr[2:0];
        rep  = {8{ex_wdata[7:0]}};
      end
      2'd1: begin
        misal = ex_addr[0];
        strb  = 8'h03 << ex_addr[2:0];
        rep   = {4{ex_wdata[15:0]}};
      end
      2'd2: begin
        misal = |ex_addr[1:0];
        strb  = 8'h0F << ex_addr[2:0];
        rep   = {2{ex_wdata[31:0]}};
      end
      default: misal = |ex_addr[2:0];
    endcase
  end

  assign shifted = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    unique case (funct3_q)
      3'b000:  ext = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ext = {56'd0, shifted[7:0]};
      3'b101:  ext = {48'd0, shifted[15:0]};
      3'b110:  ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    ex_ready       = 1'b0;
    dmem_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (accept && !fault) state_nxt = REQ;
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_nxt = load_q ? WAIT : IDLE;
      end
      WAIT: if (dmem_rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      dmem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_wstrb <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      exc_valid  <= 1'b0;
      exc_cause  <= '0;
      exc_addr   <= '0;
    end else begin
      state     <= state_nxt;
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      if (accept) begin
        if (fault) begin
          exc_valid <= 1'b1;
          exc_cause <= cause;
          exc_addr  <= ex_addr;
        end else begin
          // Request fields are held in registers so they stay stable across stalls.
          load_q     <= ex_is_load;
          funct3_q   <= ex_funct3;
          off_q      <= ex_addr[2:0];
          rd_q       <= ex_rd;
          dmem_addr  <= {ex_addr[XLEN-1:3], 3'b000};
          dmem_we    <= !ex_is_load;
          dmem_wstrb <= ex_is_load ? '0 : strb;
          dmem_wdata <= ex_is_load ? '0 : rep;
        end
      end
      if (state == WAIT && dmem_rsp_valid) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_q;
        wb_data  <= ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: directed corner ops, then random ops
// checked cycle by cycle against a byte-level behavioural model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic        wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---- reference model: access size in bytes and byte-level arithmetic ----
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [2:0] off,
                                         input logic [63:0] rdata);
    int sz = m_size(f3);
    logic [63:0] v = rdata >> (8 * off);
    logic [63:0] mask;
    if (sz < 8) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [2:0] off);
    int s = ((1 << m_size(f3)) - 1) << off;
    return s[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [2:0] f3, input logic [63:0] rs2);
    logic [63:0] r;
    int sz = m_size(f3);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = rs2[8*(i % sz) +: 8];
    return r;
  endfunction

  // Returns -1 when the op is accepted into the memory path, else the cause.
  function automatic int m_fault(input logic ld, input logic [2:0] f3, input logic [63:0] a);
    if (f3 == 3'b111 || (!ld && f3[2])) return 2;
    if ((a % m_size(f3)) != 0) return ld ? 0 : 1;
    return -1;
  endfunction

  // One complete op, driven and checked at negedges. rst_at: 0 none, 1 in REQ, 2 in WAIT.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] rdata, input int rdly, input int sdly,
                        input int rst_at);
    int flt;
    logic eff_ld;
    chk("ex_ready_idle", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    @(negedge clk);
    ex_valid = 1'b0; ex_is_load = $urandom; ex_is_store = $urandom;
    ex_addr = {$urandom, $urandom}; ex_wdata = {$urandom, $urandom};
    ex_funct3 = 3'($urandom); ex_rd = 5'($urandom);
    if (!ld && !st) begin
      chk("ignored_req", dmem_req_valid, 1'b0);
      chk("ignored_exc", exc_valid, 1'b0);
      chk("ignored_ready", ex_ready, 1'b1);
      return;
    end
    eff_ld = ld;
    flt = m_fault(eff_ld, f3, a);
    if (flt >= 0) begin
      chk("exc_valid", exc_valid, 1'b1);
      chk("exc_cause", exc_cause, 64'(flt));
      chk("exc_addr", exc_addr, a);
      chk("exc_no_req", dmem_req_valid, 1'b0);
      chk("exc_ready", ex_ready, 1'b1);
      @(negedge clk);
      chk("exc_pulse", exc_valid, 1'b0);
      chk("exc_no_req2", dmem_req_valid, 1'b0);
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      chk("req_valid", dmem_req_valid, 1'b1);
      chk("req_addr", dmem_addr, {a[63:3], 3'b000});
      chk("req_we", dmem_we, !eff_ld);
      chk("req_wstrb", dmem_wstrb, eff_ld ? 8'h00 : m_strb(f3, a[2:0]));
      if (!eff_ld) chk("req_wdata", dmem_wdata, m_wdata(f3, wd));
      chk("req_ex_ready", ex_ready, 1'b0);
      chk("req_no_wb", wb_valid, 1'b0);
      if (i == rdly) dmem_req_ready = 1'b1;
      else begin
        dmem_rsp_valid = $urandom_range(0, 1);
        dmem_rdata = {$urandom, $urandom};
      end
      if (rst_at == 1 && i == rdly) begin
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; rst = 1'b1;
      end
      @(negedge clk);
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    end
    if (rst_at == 1) begin
      rst = 1'b0;
      chk("rstreq_valid", dmem_req_valid, 1'b0);
      chk("rstreq_ready", ex_ready, 1'b1);
      return;
    end
    if (!eff_ld) begin
      chk("st_done_ready", ex_ready, 1'b1);
      chk("st_done_req", dmem_req_valid, 1'b0);
      chk("st_no_wb", wb_valid, 1'b0);
      @(negedge clk);
      chk("st_no_wb2", wb_valid, 1'b0);
      return;
    end
    if (rst_at == 2) begin
      chk("wait_ready", ex_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstwait_ready", ex_ready, 1'b1);
      chk("rstwait_req", dmem_req_valid, 1'b0);
      chk("rstwait_wb", wb_valid, 1'b0);
      @(negedge clk);
      dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("late_rsp_wb", wb_valid, 1'b0);
        chk("late_rsp_ready", ex_ready, 1'b1);
        @(negedge clk);
      end
      return;
    end
    for (int i = 0; i <= sdly; i++) begin
      chk("wait_ready", ex_ready, 1'b0);
      chk("wait_req", dmem_req_valid, 1'b0);
      chk("wait_no_wb", wb_valid, 1'b0);
      if (i == sdly) begin dmem_rsp_valid = 1'b1; dmem_rdata = rdata; end
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      dmem_rdata = {$urandom, $urandom};
    end
    chk("wb_valid", wb_valid, 1'b1);
    chk("wb_rd", wb_rd, rd);
    chk("wb_data", wb_data, m_load(f3, a[2:0], rdata));
    chk("wb_ex_ready", ex_ready, 1'b1);
    @(negedge clk);
    chk("wb_pulse", wb_valid, 1'b0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [63:0] a;
    logic        ld, st;
    rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_req_valid", dmem_req_valid, 1'b0);
    chk("rst_dmem_addr", dmem_addr, 64'd0);
    chk("rst_wstrb", dmem_wstrb, 8'd0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_exc_valid", exc_valid, 1'b0);
    chk("rst_exc_addr", exc_addr, 64'd0);

    // Directed corner cases
    run_op(1, 0, 3'b000, 64'h1003, 0, 5'd1, 64'h00000000_80000000, 0, 0, 0); // LB
    run_op(1, 0, 3'b100, 64'h1003, 0, 5'd2, 64'h00000000_80000000, 0, 0, 0); // LBU
    run_op(0, 1, 3'b001, 64'h2006, 64'h1234, 5'd0, 0, 0, 0, 0);              // SH
    run_op(1, 0, 3'b010, 64'h1002, 0, 5'd3, 0, 0, 0, 0);                     // LW misaligned
    run_op(1, 0, 3'b011, 64'h3000, 0, 5'd4, 64'h80000000_00000001, 3, 0, 0); // LD stalled
    run_op(1, 0, 3'b110, 64'h4004, 0, 5'd5, 64'hDEADBEEF_00000000, 0, 0, 0); // LWU
    run_op(1, 0, 3'b010, 64'h4004, 0, 5'd6, 64'hDEADBEEF_00000000, 0, 0, 0); // LW
    run_op(0, 1, 3'b011, 64'h5004, 64'h1, 5'd0, 0, 0, 0, 0);                 // SD misaligned
    run_op(0, 1, 3'b100, 64'h5000, 64'h1, 5'd0, 0, 0, 0, 0);                 // store funct3[2]
    run_op(1, 0, 3'b111, 64'h5000, 0, 5'd0, 0, 0, 0, 0);                     // funct3 111
    run_op(0, 0, 3'b000, 64'h6000, 0, 5'd0, 0, 0, 0, 0);                     // no flags
    run_op(1, 1, 3'b001, 64'h6006, 64'hAAAA, 5'd7, 64'h8001_0000_0000_0000, 1, 2, 0); // both
    run_op(0, 1, 3'b000, 64'h7007, 64'h5A, 5'd0, 0, 2, 0, 0);                // SB top lane
    run_op(1, 0, 3'b011, 64'h8000, 0, 5'd8, 64'h1234, 0, 0, 2);              // rst in WAIT
    run_op(0, 1, 3'b010, 64'h9004, 64'h77, 5'd0, 0, 1, 0, 1);                // rst in REQ
    run_op(1, 0, 3'b001, 64'hA002, 0, 5'd9, 64'h0000_8765_0000_0000, 0, 0, 0);

    // Randomized ops
    for (int n = 0; n < 300; n++) begin
      f3 = 3'($urandom);
      ld = ($urandom_range(0, 9) < 5);
      st = ld ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) != 0);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      if (f3 == 3'b111 || (!ld && f3[2])) a[2:0] = 3'b000;
      run_op(ld, st, f3, a, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
